// File: rtl/gol_pkg.sv
// Shared types and constants for the 8x8 RGB Game of Life display path.
package gol_pkg;

    localparam int GRID_N = 8;
    localparam int CLK_HZ = 12_000_000;
    localparam int DISP_W = GRID_N * GRID_N;
    localparam int HOLD_W = 24;

    typedef enum logic [2:0] {
        SCHED_IDLE  = 3'd0,
        SCHED_STEP  = 3'd1,
        SCHED_LATCH = 3'd2,
        SCHED_SEND  = 3'd3,
        SCHED_HOLD  = 3'd4
    } sched_state_t;

    // The timer counts down to zero inclusive, so it is loaded with one less than the hold length.
    function automatic logic [HOLD_W-1:0] hold_load(input int unsigned cycles);
        return HOLD_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/gol_hold_timer.sv
// Loadable 24-bit down-counter that times the idle gap between frames.
module gol_hold_timer
    import gol_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_load,
    input  logic [HOLD_W-1:0] i_load_val,
    input  logic              i_dec,
    output logic              o_zero
);

    logic [HOLD_W-1:0] r_count;

    // NOTE: sequential state is only ever written with <= so every reader sees the pre-edge value.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/gol_frame_scheduler.sv
// Sequences engine step, display latch, LED transmit and frame hold.
// Optional stall detection is enabled by defining GOL_STALL_DETECT_EN.
module gol_frame_scheduler
    import gol_pkg::*;
#(
    parameter int unsigned FRAME_HOLD_CYCLES = 6_000_000,
    parameter int          GEN_W             = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             step_req,
    output logic             step_start,
    input  logic             step_done,
    input  logic             gen_changed,
    output logic             frame_latch,
    output logic             led_start,
    input  logic             led_done,
    output logic             busy,
    output logic [GEN_W-1:0] gen_count,
    output logic             stalled
);

    localparam logic [2:0] ST_IDLE  = SCHED_IDLE;
    localparam logic [2:0] ST_STEP  = SCHED_STEP;
    localparam logic [2:0] ST_LATCH = SCHED_LATCH;
    localparam logic [2:0] ST_SEND  = SCHED_SEND;
    localparam logic [2:0] ST_HOLD  = SCHED_HOLD;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = hold_load(FRAME_HOLD_CYCLES);

    logic [2:0]       r_state;
    logic [2:0]       w_next;
    logic             r_step_start, r_frame_latch, r_led_start, r_busy;
    logic [GEN_W-1:0] r_gen_count;
    logic             w_step_start, w_frame_latch, w_led_start;
    logic             w_hold_load, w_hold_dec, w_hold_zero;
    logic             w_stalled;

`ifdef GOL_STALL_DETECT_EN
    logic r_stalled, r_run_q;
    logic w_run_rise;

    assign w_run_rise = run & ~r_run_q;

    // An unchanged generation freezes the pattern until reset or a fresh rising edge of run.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stalled <= 1'b0;
            r_run_q   <= 1'b0;
        end else begin
            r_run_q <= run;
            if (w_run_rise) begin
                r_stalled <= 1'b0;
            end else if ((r_state == ST_STEP) && step_done && !gen_changed) begin
                r_stalled <= 1'b1;
            end
        end
    end

    assign w_stalled = r_stalled;
`else
    logic w_unused_gen_changed;

    assign w_unused_gen_changed = gen_changed;
    assign w_stalled            = 1'b0;
`endif

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_next        = r_state;
        w_step_start  = 1'b0;
        w_frame_latch = 1'b0;
        w_led_start   = 1'b0;
        w_hold_load   = 1'b0;
        w_hold_dec    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_stalled && (run || step_req)) begin
                    w_step_start = 1'b1;
                    w_next       = ST_STEP;
                end
            end
            ST_STEP: begin
                if (step_done) begin
                    w_frame_latch = 1'b1;
                    w_next        = ST_LATCH;
                end
            end
            ST_LATCH: begin
                w_led_start = 1'b1;
                w_next      = ST_SEND;
            end
            ST_SEND: begin
                if (led_done) begin
                    w_hold_load = 1'b1;
                    w_next      = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!w_hold_zero) begin
                    w_hold_dec = 1'b1;
                end else if (run && !w_stalled) begin
                    w_step_start = 1'b1;
                    w_next       = ST_STEP;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Pulse outputs are registered copies of the decode, so each fires the cycle after its cause.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_step_start  <= 1'b0;
            r_frame_latch <= 1'b0;
            r_led_start   <= 1'b0;
            r_busy        <= 1'b0;
            r_gen_count   <= '0;
        end else begin
            r_state       <= w_next;
            r_step_start  <= w_step_start;
            r_frame_latch <= w_frame_latch;
            r_led_start   <= w_led_start;
            r_busy        <= (w_next != ST_IDLE);
            if (w_frame_latch) begin
                r_gen_count <= r_gen_count + GEN_W'(1);
            end
        end
    end

    gol_hold_timer u_hold_timer (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_load     (w_hold_load),
        .i_load_val (HOLD_LOAD),
        .i_dec      (w_hold_dec),
        .o_zero     (w_hold_zero)
    );

    assign step_start  = r_step_start;
    assign frame_latch = r_frame_latch;
    assign led_start   = r_led_start;
    assign busy        = r_busy;
    assign gen_count   = r_gen_count;
    assign stalled     = w_stalled;

endmodule

// File: doc/gol_frame_scheduler.md
# gol_frame_scheduler

Sequencer for the 8x8 RGB Game of Life display path. Decides when the life engine computes the next generation, when the computed generation is latched into the green/red/blue display arrays, when the LED serializer transmits a frame, and how long each frame is held. Sits in `top` between the `SW`/`BOOT` user inputs, the life engine and the LED serializer driving `_48b`.

## Interface
- `FRAME_HOLD_CYCLES`, 6_000_000: idle cycles between the end of a transmission and the next step (0.5 s at 12 MHz); legal range 1..2^24-1.
- `GEN_W`, 16: generation counter width.
- `clk` in 1: system clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high; one clock with `reset` = 1 resets every register.
- `run` in 1: level; 1 = free-running generations (wired to `SW`).
- `step_req` in 1: one-cycle pulse, already debounced; requests one generation while `run` = 0 (from `BOOT`).
- `step_start` out 1: one-cycle pulse; life engine starts computing the next generation.
- `step_done` in 1: one-cycle pulse; engine result is valid.
- `gen_changed` in 1: qualified by `step_done`; 1 = the new generation differs from the current one.
- `frame_latch` out 1: one-cycle pulse; `top` copies the engine result into the display arrays on this edge.
- `led_start` out 1: one-cycle pulse; serializer begins transmitting the display arrays.
- `led_done` in 1: one-cycle pulse; serializer has finished the frame, including the latch gap.
- `busy` out 1: 1 in every state except IDLE.
- `gen_count` out GEN_W: count of latched generations.
- `stalled` out 1: pattern frozen (see Configuration).

## Operation
- States: IDLE, STEP, LATCH, SEND, HOLD.
- IDLE: if `run` = 1 or `step_req` = 1 (and not `stalled`), assert `step_start` and go to STEP. Otherwise stay in IDLE.
- STEP: wait for `step_done`. On `step_done`, capture `gen_changed` and go to LATCH.
- LATCH: assert `frame_latch` for one cycle and increment `gen_count`. `gen_count` wraps from 2^GEN_W-1 to 0. Next cycle: assert `led_start` and go to SEND.
- SEND: wait for `led_done`, then load the hold counter with FRAME_HOLD_CYCLES-1 and go to HOLD.
- HOLD: decrement the counter to 0, then:
  - if `run` = 1, assert `step_start` and go to STEP;
  - otherwise go to IDLE.
- `step_req` is honoured only in IDLE. Pulses arriving in any other state are dropped; they are not queued.
- `step_done` and `led_done` are ignored outside STEP and SEND respectively.
- `run` falling mid-cycle: the current generation completes through HOLD, then the block goes to IDLE.
- `run` = 1 and `step_req` in the same IDLE cycle: exactly one `step_start`.

## Timing
- Reset values:
  - state = IDLE;
  - `step_start`, `frame_latch`, `led_start`, `busy`, `stalled` = 0;
  - `gen_count` = 0;
  - hold counter = 0.
- Outputs are registered. `step_start` rises the cycle after IDLE samples `run`/`step_req`.
- `step_done` → `frame_latch`: 1 cycle. `frame_latch` → `led_start`: 1 cycle.
- `led_done` → next `step_start` (with `run` = 1): FRAME_HOLD_CYCLES + 1 cycles.
- `reset` mid-operation: next state is IDLE and no pulse outputs fire. A `step_done`/`led_done` arriving in that same cycle is discarded.

## Configuration
- `GOL_STALL_DETECT_EN` defined:
  - in LATCH, if the captured `gen_changed` = 0, set `stalled` = 1;
  - after HOLD, go to IDLE regardless of `run`;
  - while `stalled` = 1, IDLE ignores `run` and `step_req`;
  - `stalled` clears on `reset` or on a rising edge of `run`.
- Undefined: `stalled` is tied to 0, `gen_changed` is unused, and the pattern runs indefinitely.

## Structure
- Package `gol_pkg`:
  - `sched_state_t` enum;
  - `GRID_N = 8`;
  - `CLK_HZ = 12_000_000`;
  - display array width `GRID_N*GRID_N`.
- One sub-module, `gol_hold_timer`: 24-bit loadable down-counter with a `zero` flag, used for HOLD.

## Test plan
- Reset with `run` = 0 held 20 cycles → all outputs 0; `gen_count` = 0; no pulses.
- FRAME_HOLD_CYCLES = 10, `run` = 1, engine replies `step_done` 5 cycles after `step_start`, serializer replies `led_done` 30 cycles after `led_start` → period from one `step_start` to the next = 5+1+1+30+11 = 48 cycles; `gen_count` reads 1, 2, 3.
- `run` = 0, single `step_req` → exactly one `step_start`/`frame_latch`/`led_start`, then IDLE. A second `step_req` issued during SEND → ignored; `gen_count` = 1.
- `run` dropped during SEND → cycle finishes HOLD, returns to IDLE; `busy` = 0 one cycle after the hold expires.
- `GOL_STALL_DETECT_EN`, `run` = 1, third `step_done` with `gen_changed` = 0 → `stalled` = 1 at that generation's `frame_latch`; IDLE after HOLD; a `run` 0→1 toggle clears `stalled` and restarts.
- `reset` asserted in STEP simultaneously with `step_done` → no `frame_latch`; `gen_count` = 0; state IDLE.
